// File: rtl/seq_div_16by8.sv
// seq_div_16by8 -- sequential 16-by-8 unsigned restoring divider.
//
// One division takes 16 RUN cycles. Each cycle produces one quotient bit,
// most significant bit first, from a 9-bit partial remainder. A zero divisor
// skips the iterations and returns all-ones with div0 set.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   request; accepted on a rising edge while busy is low
//   dividend  in  16   unsigned dividend, captured when start is accepted
//   divisor   in   8   unsigned divisor, captured when start is accepted
//   busy      out  1   high from the accepting edge until the completing edge
//   done      out  1   one-cycle completion strobe (registered)
//   quot      out 16   quotient of the last completed division
//   rem       out  8   remainder of the last completed division
//   div0      out  1   last completed division had a zero divisor
//   dbg_state out  2   current FSM state, for observation only
//
// Handshake: start is a request qualified by busy. A request that meets
// busy=0 at the sampling edge is accepted and its operands are captured.
// A request that meets busy=1 is dropped and changes nothing. Each accepted
// request produces exactly one done pulse unless reset intervenes first.
module seq_div_16by8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot,
  output logic [7:0]  rem,
  output logic        div0,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  // Starts out holding the dividend. Each step shifts the next dividend bit
  // out at the top and shifts the new quotient bit in at the bottom.
  logic [15:0] dq;
  logic [7:0]  dvs;
  logic [7:0]  prem;

  logic [8:0]  trial;
  logic        qbit;
  logic [7:0]  next_rem;

  // One restoring step. When the trial value is at least the divisor, the
  // difference is below the divisor and therefore fits in 8 bits. This makes
  // an 8-bit subtract sufficient.
  always_comb begin
    trial    = {prem, dq[15]};
    qbit     = (trial >= {1'b0, dvs});
    next_rem = qbit ? (trial[7:0] - dvs) : trial[7:0];
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      dq    <= 16'd0;
      dvs   <= 8'd0;
      prem  <= 8'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      quot  <= 16'd0;
      rem   <= 8'd0;
      div0  <= 1'b0;
    end else begin
      case (state)
        // DONE behaves like IDLE for acceptance, so requests can run back to back.
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            dq    <= dividend;
            dvs   <= divisor;
            prem  <= 8'd0;
            cnt   <= 4'd0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (dvs == 8'd0) begin
            quot  <= 16'hFFFF;
            rem   <= 8'hFF;
            div0  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            dq   <= {dq[14:0], qbit};
            prem <= next_rem;
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              quot  <= {dq[14:0], qbit};
              rem   <= next_rem;
              div0  <= 1'b0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_16by8.sv
// Testbench for seq_div_16by8. Expected results come from plain div/mod
// arithmetic and are queued when a request is issued. A monitor pops and
// compares one entry on every done pulse.
module tb_seq_div_16by8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        div0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  seq_div_16by8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quot      (quot),
    .rem       (rem),
    .div0      (div0),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [24:0] exp_q[$];   // {quot, rem, div0}
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] q;
    logic [15:0] r;
    if (b == 8'd0) return {16'hFFFF, 8'hFF, 1'b1};
    q = a / {8'd0, b};
    r = a % {8'd0, b};
    return {q, r[7:0], 1'b0};
  endfunction

  // ---------------- monitor ----------------
  logic        prev_done = 1'b0;
  logic [15:0] held_q = 16'd0;
  logic [7:0]  held_r = 8'd0;
  logic        held_z = 1'b0;
  logic        stable_ok = 1'b1;

  always @(negedge clk) begin
    logic [24:0] e;
    if (!rst_n) begin
      prev_done = 1'b0;
      held_q    = 16'd0;
      held_r    = 8'd0;
      held_z    = 1'b0;
      stable_ok = 1'b1;
    end else begin
      if (busy && (quot !== held_q || rem !== held_r || div0 !== held_z))
        stable_ok = 1'b0;
      if (done) begin
        check("done_not_consecutive", {31'd0, prev_done}, 32'd0);
        check("outputs_stable_during_run", {31'd0, stable_ok}, 32'd1);
        stable_ok = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_quot_rem_div0", {7'd0, quot, rem, div0}, {7'd0, e});
        end
        held_q = quot;
        held_r = rem;
        held_z = div0;
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issues one request with a single-cycle start pulse, then scrambles the inputs.
  // Returns at the negedge following the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b, input logic [24:0] expv);
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Counts negedges from the accepting edge until done.
  // n0 is the number of negedges already elapsed since that edge.
  task automatic latency(input int n0, input int exp_n);
    int   n  = n0;
    logic ok = busy;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (!done && !busy) ok = 1'b0;
    end
    check("done_latency", n, exp_n);
    check("busy_while_running", {31'd0, ok}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 8'd0;
    #7;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quot", {16'd0, quot}, 32'd0);
    check("reset_rem",  {24'd0, rem},  32'd0);
    check("reset_div0", {31'd0, div0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases: the first request arrives on the first edge after reset release.
    start_op(16'd1000, 8'd7, {16'd142, 8'd6, 1'b0});
    latency(1, 17);
    start_op(16'hFFFF, 8'h01, {16'hFFFF, 8'h00, 1'b0});
    latency(1, 17);
    start_op(16'hFFFF, 8'hFF, {16'h0101, 8'h00, 1'b0});
    latency(1, 17);
    start_op(16'h0005, 8'h09, {16'h0000, 8'h05, 1'b0});
    latency(1, 17);
    start_op(16'h1234, 8'h00, {16'hFFFF, 8'hFF, 1'b1});
    latency(1, 2);
    start_op(16'd1000, 8'd7, model(16'd1000, 8'd7));
    latency(1, 17);

    // A second start while busy is ignored.
    start_op(16'd1000, 8'd7, model(16'd1000, 8'd7));
    repeat (4) @(negedge clk);
    dividend = 16'h5555;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    latency(6, 17);

    // Start held high through DONE: the second operation follows with no idle gap.
    wait_idle();
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    exp_q.push_back(model(16'd1000, 8'd7));
    @(negedge clk);
    dividend = 16'd40000;
    divisor  = 8'd201;
    exp_q.push_back(model(16'd40000, 8'd201));
    latency(1, 17);
    @(negedge clk);
    start = 1'b0;
    latency(1, 17);

    // Reset in the middle of RUN.
    start_op(16'hBEEF, 8'h3C, model(16'hBEEF, 8'h3C));
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", {31'd0, busy}, 32'd0);
    check("midrun_reset_done", {31'd0, done}, 32'd0);
    check("midrun_reset_quot", {16'd0, quot}, 32'd0);
    check("midrun_reset_rem",  {24'd0, rem},  32'd0);
    check("midrun_reset_div0", {31'd0, div0}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    start_op(16'd5000, 8'd13, model(16'd5000, 8'd13));
    latency(1, 17);

    // Random exact products: the quotient must recover a with zero remainder.
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      start_op(a * {8'd0, b}, b, {a, 8'd0, 1'b0});
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Random unconstrained operands, including an occasional zero divisor.
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      start_op(a, b, model(a, b));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
